// File: rtl/addsub_seq_ctrl.sv
// Byte-serial add/subtract sequencer: chains carry across NBYTES operand byte pairs, LSB-first.
// Optional signed-overflow flag is enabled by defining ADDSUB_OVF_FLAG_EN.
`timescale 1ns/1ps

module addsub_seq_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       op_sub,
    input  logic       abort,
    input  logic [7:0] a_byte,
    input  logic [7:0] b_byte,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] res_byte,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       busy,
    output logic       done,
    output logic       carry_out,
    output logic       overflow
);

    localparam int CW = $clog2(NBYTES + 1);
    localparam logic [CW-1:0] LAST   = CW'(NBYTES);
    localparam logic [CW-1:0] PENULT = CW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_OUT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic            mode_r;
    logic            carry_r;
    logic [CW-1:0]   count_r;
    logic [7:0]      res_byte_r;
    logic            in_ready_r;
    logic            res_valid_r;
    logic            busy_r;
    logic            done_r;
    logic            carry_out_r;
    logic            start_s;
    logic            accept_s;
    logic            finish_s;
    logic [7:0]      a_eff_s;
    logic [8:0]      sum_s;

    assign in_ready  = in_ready_r;
    assign res_byte  = res_byte_r;
    assign res_valid = res_valid_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign carry_out = carry_out_r;

    // Next-state decode and per-cycle event strobes; abort pre-empts every transition.
    always_comb begin
        state_s  = state_r;
        start_s  = 1'b0;
        accept_s = 1'b0;
        finish_s = 1'b0;
        a_eff_s  = mode_r ? ~a_byte : a_byte;
        sum_s    = {1'b0, a_eff_s} + {1'b0, b_byte} + {8'd0, carry_r};
        if (abort) begin
            state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        start_s = 1'b1;
                        state_s = S_RUN;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (in_valid) begin
                        accept_s = 1'b1;
                        state_s  = S_OUT;
                    end else begin
                        state_s = S_RUN;
                    end
                end
                S_OUT: begin
                    if (res_ready && (count_r == LAST)) begin
                        finish_s = 1'b1;
                        state_s  = S_DONE;
                    end else if (res_ready) begin
                        state_s = S_RUN;
                    end else begin
                        state_s = S_OUT;
                    end
                end
                S_DONE:  state_s = S_IDLE;
                default: state_s = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Handshake and status outputs come straight from flops, decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b0;
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            in_ready_r  <= (state_s == S_RUN);
            res_valid_r <= (state_s == S_OUT);
            busy_r      <= (state_s != S_IDLE);
            done_r      <= (state_s == S_DONE);
        end
    end

    // Datapath: mode, carry chain, byte counter, result byte and final carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r      <= 1'b0;
            carry_r     <= 1'b0;
            count_r     <= '0;
            res_byte_r  <= 8'd0;
            carry_out_r <= 1'b0;
        end else if (start_s) begin
            mode_r      <= op_sub;
            carry_r     <= op_sub;
            count_r     <= '0;
            carry_out_r <= 1'b0;
        end else if (accept_s) begin
            res_byte_r  <= sum_s[7:0];
            carry_r     <= sum_s[8];
            count_r     <= count_r + CW'(1);
        end else if (finish_s) begin
            carry_out_r <= carry_r;
        end
    end

`ifdef ADDSUB_OVF_FLAG_EN
    logic ovf_pend_r;
    logic overflow_r;

    assign overflow = overflow_r;

    // Overflow is captured on the final byte, then published alongside carry_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_pend_r <= 1'b0;
            overflow_r <= 1'b0;
        end else if (start_s) begin
            ovf_pend_r <= 1'b0;
            overflow_r <= 1'b0;
        end else if (accept_s && (count_r == PENULT)) begin
            ovf_pend_r <= (a_eff_s[7] == b_byte[7]) && (sum_s[7] != b_byte[7]);
        end else if (finish_s) begin
            overflow_r <= ovf_pend_r;
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Scoreboard bench for addsub_seq_ctrl: driver pushes model results, negedge monitor pops and compares.
`timescale 1ns/1ps

module tb_addsub_seq_ctrl;

    localparam int NB = 4;
    localparam int W  = NB * 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       op_sub = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] a_byte = 8'd0;
    logic [7:0] b_byte = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] res_byte;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic       busy;
    logic       done;
    logic       carry_out;
    logic       overflow;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_bytes[$];
    logic [1:0] exp_final[$];
    bit         prev_done = 1'b0;
    logic [7:0] mon_e;
    logic [1:0] mon_f;

    addsub_seq_ctrl #(.NBYTES(NB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .abort(abort),
        .a_byte(a_byte), .b_byte(b_byte), .in_valid(in_valid), .in_ready(in_ready),
        .res_byte(res_byte), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .done(done), .carry_out(carry_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit sig_val(input int sel);
        case (sel)
            0:       return res_valid;
            1:       return in_ready;
            2:       return !busy;
            default: return done;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input string name);
        int n = 0;
        while (!sig_val(sel) && n < 30) begin
            step();
            n++;
        end
        if (!sig_val(sel)) begin
            n_checks++;
            $display("FAIL timeout_%s: not seen after %0d cycles, required within 30", name, n);
        end
    endtask

    // Reference: whole-word arithmetic; B-A as B+~A+1, signed overflow from operand/result signs.
    function automatic void model(input logic [63:0] a, input logic [63:0] b, input bit sub,
                                  output logic [63:0] r, output bit c, output bit v);
        logic [63:0] mask;
        logic [63:0] am;
        logic [63:0] bm;
        logic [63:0] ae;
        logic [64:0] full;
        bit sa, sb, sr;
        mask = (W == 64) ? {64{1'b1}} : ((64'd1 << W) - 64'd1);
        am   = a & mask;
        bm   = b & mask;
        ae   = sub ? (~a & mask) : am;
        full = {1'b0, bm} + {1'b0, ae} + {64'd0, sub};
        r    = full[63:0] & mask;
        c    = full[W];
        sa   = am[W-1];
        sb   = bm[W-1];
        sr   = r[W-1];
        v    = sub ? ((sa != sb) && (sr != sb)) : ((sa == sb) && (sr != sb));
`ifndef ADDSUB_OVF_FLAG_EN
        v = 1'b0;
`endif
    endfunction

    // Monitor: consumes every accepted result byte and every done pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (res_valid && res_ready) begin
                if (exp_bytes.size() == 0) begin
                    n_checks++;
                    $display("FAIL res_unexpected: got byte %02h, required no output", res_byte);
                end else begin
                    mon_e = exp_bytes.pop_front();
                    check("res_byte", {56'd0, res_byte}, {56'd0, mon_e});
                end
            end
            if (done) begin
                if (prev_done) begin
                    n_checks++;
                    $display("FAIL done_width: got done high 2 cycles, required 1");
                end
                if (exp_final.size() == 0) begin
                    n_checks++;
                    $display("FAIL done_unexpected: got done=1, required 0");
                end else begin
                    mon_f = exp_final.pop_front();
                    check("carry_out", {63'd0, carry_out}, {63'd0, mon_f[1]});
                    check("overflow", {63'd0, overflow}, {63'd0, mon_f[0]});
                end
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // kill: 0 none, 1 abort, 2 reset, applied after kill_after bytes have been consumed.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input bit sub,
                          input int kill, input int kill_after, input bit hold);
        logic [63:0] r;
        bit c, v;
        model(a, b, sub, r, c, v);
        wait_sig(2, "idle");
        start = 1'b1;
        op_sub = sub;
        step();
        start = 1'b0;
        op_sub = 1'($urandom);
        for (int i = 0; i < NB; i++) begin
            repeat ($urandom_range(0, 2)) step();
            exp_bytes.push_back(r[8*i +: 8]);
            if (i == NB - 1 && kill == 0) exp_final.push_back({c, v});
            a_byte = a[8*i +: 8];
            b_byte = b[8*i +: 8];
            in_valid = 1'b1;
            wait_sig(1, "in_ready");
            step();
            in_valid = 1'b0;
            a_byte = 8'($urandom);
            b_byte = 8'($urandom);
            wait_sig(0, "res_valid");
            repeat ($urandom_range(0, 2)) step();
            if (hold && i == 1) begin
                for (int k = 0; k < 5; k++) begin
                    in_valid = 1'b1;
                    a_byte = 8'($urandom);
                    start = 1'b1;
                    op_sub = !sub;
                    step();
                    check("hold_byte", {56'd0, res_byte}, {56'd0, r[15:8]});
                    check("hold_valid", {63'd0, res_valid}, 64'd1);
                    check("hold_in_ready", {63'd0, in_ready}, 64'd0);
                end
                in_valid = 1'b0;
                start = 1'b0;
            end
            res_ready = 1'b1;
            step();
            res_ready = 1'b0;
            if (kill == 1 && i + 1 == kill_after) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                check("abort_busy", {63'd0, busy}, 64'd0);
                check("abort_in_ready", {63'd0, in_ready}, 64'd0);
                check("abort_res_valid", {63'd0, res_valid}, 64'd0);
                check("abort_carry_out", {63'd0, carry_out}, 64'd0);
                check("abort_overflow", {63'd0, overflow}, 64'd0);
                return;
            end
            if (kill == 2 && i + 1 == kill_after) begin
                rst_n = 1'b0;
                #1;
                check("rst_outputs", {51'd0, in_ready, res_byte, res_valid, busy, done, carry_out, overflow}, 64'd0);
                step();
                rst_n = 1'b1;
                return;
            end
        end
        wait_sig(3, "done");
        step();
    endtask

    initial begin
        repeat (3) step();
        check("reset_outputs", {51'd0, in_ready, res_byte, res_valid, busy, done, carry_out, overflow}, 64'd0);
        rst_n = 1'b1;
        step();
        check("idle_busy", {63'd0, busy}, 64'd0);

        run_op(64'h11111111, 64'h12345678, 1'b0, 0, 0, 1'b0);
        run_op(64'hFFFFFFFF, 64'h00000001, 1'b0, 0, 0, 1'b0);
        run_op(64'h00000001, 64'h00000000, 1'b1, 0, 0, 1'b0);
        run_op(64'h00000005, 64'h00000005, 1'b1, 0, 0, 1'b0);
        run_op(64'h11111111, 64'h12345678, 1'b0, 0, 0, 1'b1);
        run_op(64'hFFFFFFFF, 64'h00000001, 1'b0, 0, 0, 1'b0);
        run_op(64'hFFFFFFFF, 64'h00000001, 1'b0, 1, 2, 1'b0);
        run_op(64'h11111111, 64'h12345678, 1'b0, 0, 0, 1'b0);

        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", {63'd0, busy}, 64'd0);
        check("start_abort_in_ready", {63'd0, in_ready}, 64'd0);

        run_op(64'h89ABCDEF, 64'h01234567, 1'b1, 2, 1, 1'b0);
        run_op(64'h89ABCDEF, 64'h01234567, 1'b1, 0, 0, 1'b0);
        run_op(64'h00000001, 64'h7FFFFFFF, 1'b0, 0, 0, 1'b0);
        run_op(64'h00000001, 64'h80000000, 1'b1, 0, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 0, 0, 1'($urandom_range(0, 7) == 0));
        end

        wait_sig(2, "final_idle");
        step();
        check("sb_empty", 64'(exp_bytes.size() + exp_final.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
